combo_lock_fsm: RTL and testbench

Four-button combination lock controller that consumes the single-press pulses produced by the push-button detection stage, one detector per button. It checks a fixed 4-press code, holds an unlock output for a bounded time on success, and counts failed attempts. When the failure limit is reached it latches an alarm. It sits directly downstream of the push-button detectors and upstream of the LED/relay outputs.

---
 rtl/combo_lock_fsm.sv | 156 +++++++++++++++
 tb/tb_combo_lock_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_fsm.sv
// Four-button combination lock: qualifies press pulses, checks a 4-press code,
// times the unlock window and entry idle gaps, and latches an alarm after repeated failures.
module combo_lock_fsm #(
   parameter logic [7:0] CODE          = 8'b00_01_10_11,
   parameter int         MAX_FAIL      = 3,
   parameter int         TIMEOUT       = 1000,
   parameter int         UNLOCK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   output logic       unlock,
   output logic       alarm,
   output logic       error,
   output logic [2:0] progress,
   output logic [1:0] fail_cnt
);

   localparam int CNT_MAX = (TIMEOUT > UNLOCK_CYCLES) ? TIMEOUT : UNLOCK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX);

   // Entry expires on the edge where the counter would reach TIMEOUT-1.
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);
   localparam logic [CW-1:0] UL_LAST = CW'(UNLOCK_CYCLES - 1);
   localparam logic [1:0]    FAIL_LIM = 2'(MAX_FAIL);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_OPEN,
      S_ALARM
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      btn_q, btn_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      progress_q, progress_d;
   logic            mis_q, mis_d;
   logic [1:0]      fail_q, fail_d;
   logic            error_q, error_d;

   logic [3:0]      press;
   logic            any_press;
   logic            single;
   logic [1:0]      idx;
   logic [1:0]      exp_idx;
   logic            hit;
   logic [1:0]      fail_inc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         btn_q      <= 4'b1111;
         cnt_q      <= '0;
         progress_q <= '0;
         mis_q      <= 1'b0;
         fail_q     <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         btn_q      <= btn_d;
         cnt_q      <= cnt_d;
         progress_q <= progress_d;
         mis_q      <= mis_d;
         fail_q     <= fail_d;
         error_q    <= error_d;
      end
   end

   always_comb begin
      press     = btn & ~btn_q;
      any_press = |press;
      single    = any_press && ((press & (press - 4'd1)) == 4'd0);
      case (press)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      case (progress_q[1:0])
         2'd0:    exp_idx = CODE[7:6];
         2'd1:    exp_idx = CODE[5:4];
         2'd2:    exp_idx = CODE[3:2];
         default: exp_idx = CODE[1:0];
      endcase
      hit      = single && (idx == exp_idx);
      fail_inc = fail_q + 2'd1;
   end

   always_comb begin
      state_d    = state_q;
      btn_d      = btn;
      cnt_d      = cnt_q;
      progress_d = progress_q;
      mis_d      = mis_q;
      fail_d     = fail_q;
      error_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d      = '0;
            progress_d = '0;
            if (any_press) begin
               state_d    = S_ENTRY;
               progress_d = 3'd1;
               mis_d      = !hit;
            end
         end
         S_ENTRY: begin
            if (any_press) begin
               cnt_d = '0;
               if (progress_q == 3'd3) begin
                  progress_d = '0;
                  if (!mis_q && hit) begin
                     state_d = S_OPEN;
                     fail_d  = '0;
                  end else begin
                     error_d = 1'b1;
                     fail_d  = fail_inc;
                     state_d = (fail_inc == FAIL_LIM) ? S_ALARM : S_IDLE;
                  end
               end else begin
                  progress_d = progress_q + 3'd1;
                  mis_d      = mis_q | !hit;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d    = S_IDLE;
               cnt_d      = '0;
               progress_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_OPEN: begin
            // Any press while open relocks without starting an entry.
            if (any_press || cnt_q == UL_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ALARM: begin
            cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      unlock   = (state_q == S_OPEN);
      alarm    = (state_q == S_ALARM);
      error    = error_q;
      progress = progress_q;
      fail_cnt = fail_q;
   end

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Scoreboard bench for combo_lock_fsm: expectations are queued per cycle
// when stimulus is scheduled and compared after each rising edge.
module tb_combo_lock_fsm;

   localparam int UNL = 10;
   localparam int TO  = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic       unlock;
   logic       alarm;
   logic       error;
   logic [2:0] progress;
   logic [1:0] fail_cnt;

   combo_lock_fsm #(
      .CODE         (8'b00_01_10_11),
      .MAX_FAIL     (3),
      .TIMEOUT      (TO),
      .UNLOCK_CYCLES(UNL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn),
      .unlock  (unlock),
      .alarm   (alarm),
      .error   (error),
      .progress(progress),
      .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   localparam int P = 0, U = 1, A = 2, E = 3, F = 4;

   typedef struct {
      int    at;
      int    sel;
      int    val;
      string tag;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d got %0d exp %0d", tag, cyc, act, exp);
      end
   endtask

   task automatic push(input int at, input int sel, input int val, input string tag);
      exp_t e;
      e.at  = at;
      e.sel = sel;
      e.val = val;
      e.tag = tag;
      sbq.push_back(e);
   endtask

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         P:       return 32'(progress);
         U:       return 32'(unlock);
         A:       return 32'(alarm);
         E:       return 32'(error);
         default: return 32'(fail_cnt);
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at == cyc) begin
               check(sbq[i].tag, obs(sbq[i].sel), 32'(sbq[i].val));
               sbq.delete(i);
            end
         end
      end
   end

   task automatic idle(input int n);
      btn = 4'b0000;
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] b, input int hi, input int lo);
      btn = b;
      repeat (hi) @(negedge clk);
      btn = 4'b0000;
      repeat (lo) @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] b);
      int r;
      r = cyc + 1;
      push(r, P, 0, "rst_prog");
      push(r, U, 0, "rst_unlock");
      push(r, A, 0, "rst_alarm");
      push(r, E, 0, "rst_error");
      push(r, F, 0, "rst_fail");
      rst = 1'b0;
      btn = b;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Expectations for one 4-press attempt whose first press lands at edge k.
   task automatic attempt_exp(input int k, input int per, input bit ok,
                              input int f, input bit al, input bit win);
      int e;
      e = k + 3 * per;
      for (int i = 0; i < 3; i++) begin
         push(k + i * per, P, i + 1, "att_prog");
         push(k + i * per, E, 0, "att_early_err");
      end
      push(k + 1, P, 1, "att_hold");
      push(e - 1, U, 0, "att_pre_unlock");
      push(e, P, 0, "att_prog_end");
      push(e, E, ok ? 0 : 1, "att_error");
      push(e + 1, E, 0, "att_err_pulse");
      push(e, F, f, "att_fail");
      push(e, A, al ? 1 : 0, "att_alarm");
      push(e, U, ok ? 1 : 0, "att_unlock");
      if (win) begin
         for (int j = 1; j < UNL; j++) push(e + j, U, 1, "win_unlock");
         push(e + UNL, U, 0, "win_end");
      end
   endtask

   task automatic run_code(input logic [15:0] bs, input int hi, input int lo);
      press(bs[15:12], hi, lo);
      press(bs[11:8], hi, lo);
      press(bs[7:4], hi, lo);
      press(bs[3:0], hi, lo);
   endtask

   localparam logic [15:0] GOOD = 16'b0001_0010_0100_1000;
   localparam logic [15:0] BAD  = 16'b0001_0001_0100_1000;
   localparam logic [15:0] MULT = 16'b0011_0010_0100_1000;

   initial begin
      int k, l, o;
      rst = 1'b0;
      btn = 4'b0000;
      @(negedge clk);

      // correct code, full unlock window
      do_reset(4'b0000);
      k = cyc + 1;
      attempt_exp(k, 5, 1'b1, 0, 1'b0, 1'b1);
      run_code(GOOD, 3, 2);
      idle(8);

      // three failures latch the alarm; correct code then ignored
      for (int a = 1; a <= 3; a++) begin
         k = cyc + 1;
         attempt_exp(k, 5, 1'b0, a, a == 3, 1'b0);
         run_code(BAD, 3, 2);
      end
      k = cyc + 1;
      for (int i = 0; i < 4; i++) push(k + 5 * i, P, 0, "alarm_prog");
      push(k + 15, A, 1, "alarm_hold");
      push(k + 15, F, 3, "alarm_fail");
      push(k + 15, U, 0, "alarm_unlock");
      run_code(GOOD, 3, 2);
      do_reset(4'b0000);

      // entry timeout after two presses
      k = cyc + 1;
      l = k + 5;
      push(k, P, 1, "to_p1");
      push(l, P, 2, "to_p2");
      push(l + TO - 2, P, 2, "to_before");
      push(l + TO - 1, P, 0, "to_expire");
      push(l + TO - 1, F, 0, "to_fail");
      push(l + TO - 1, E, 0, "to_error");
      press(4'b0001, 3, 2);
      press(4'b0010, 3, 2);
      idle(21);
      k = cyc + 1;
      attempt_exp(k, 5, 1'b1, 0, 1'b0, 1'b1);
      run_code(GOOD, 3, 2);
      idle(8);

      // two buttons in one cycle is a mismatching press
      k = cyc + 1;
      attempt_exp(k, 5, 1'b0, 1, 1'b0, 1'b0);
      run_code(MULT, 3, 2);

      // back-to-back single-cycle presses; success clears the fail count
      k = cyc + 1;
      for (int i = 0; i < 3; i++) push(k + 2 * i + 1, P, i + 1, "fast_gap");
      attempt_exp(k, 2, 1'b1, 0, 1'b0, 1'b1);
      run_code(GOOD, 1, 1);
      idle(12);

      // button held through reset, then a press cuts the unlock short
      do_reset(4'b0001);
      k = cyc + 1;
      for (int i = 0; i < 3; i++) push(k + i, P, 0, "held_prog");
      idle(0);
      btn = 4'b0001;
      repeat (3) @(negedge clk);
      idle(2);
      k = cyc + 1;
      o = k + 15;
      attempt_exp(k, 5, 1'b1, 0, 1'b0, 1'b0);
      push(o + 3, U, 1, "open_pre_cut");
      push(o + 4, U, 0, "open_cut");
      push(o + 4, P, 0, "open_cut_prog");
      push(o + 5, P, 0, "open_after_prog");
      push(o + 5, E, 0, "open_after_err");
      press(4'b0001, 3, 2);
      press(4'b0010, 3, 2);
      press(4'b0100, 3, 2);
      press(4'b1000, 1, 0);
      while (cyc + 1 < o + 4) @(negedge clk);
      press(4'b0100, 1, 3);
      idle(4);

      check("sb_left", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc %0d got timeout exp finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
